// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC generator: FSM state encoding and the
// default reset vector / sequential step used when a parent leaves them unset.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } pc_state_e;

  localparam logic [63:0] PC_DEFAULT_RESET_VEC = 64'h0;
  localparam int unsigned PC_DEFAULT_STEP      = 4;

endpackage

// File: rtl/pc_gen_redirect_buf.sv
// One-entry pending-redirect buffer: holds a branch target that arrived while
// fetch could not advance. A capture always overwrites whatever is held, so
// the newest branch wins; clear drops the entry.
module pc_redirect_buf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Capture (or overwrite) takes precedence over clear for the next entry value
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (capture_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry register; an asynchronous reset drops any held redirect immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage. Holds the OFF/RUN/PEND FSM,
// the PC register and the next-PC priority mux (flush > taken branch >
// pending redirect > sequential step > capture of a stalled branch).
// Optional build macro PC_GEN_MISALIGN_EN adds the misalign_o pulse output.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = PC_DEFAULT_RESET_VEC[ADDR_W-1:0],
  parameter int unsigned       STEP      = PC_DEFAULT_STEP,
  parameter int unsigned       STALL_W   = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [STALL_W-1:0] pc_stall,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               fetch_gnt_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               fetch_req_o,
`ifdef PC_GEN_MISALIGN_EN
  output logic               misalign_o,
`endif
  output logic               pend_valid_o
);

  localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q;
  logic              advance;
  logic              buf_capture, buf_clear;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;

  // Only the PC-stage stall bit matters; the rest of the vector is for other stages
  logic unused_stall;
  assign unused_stall = ^pc_stall;

  assign fetch_req_o = ce_q & ~pc_stall[0] & ~flush;
  assign advance     = fetch_req_o & fetch_gnt_i;

  // Next-PC selection and FSM transitions, highest priority first
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    if (state_q == S_OFF) begin
      state_d = S_RUN;
    end else if (flush) begin
      pc_d      = new_pc;
      buf_clear = 1'b1;
      state_d   = S_RUN;
    end else if (advance && branch_flag_i) begin
      pc_d      = branch_target_address_i;
      buf_clear = 1'b1;
      state_d   = S_RUN;
    end else if (advance && (state_q == S_PEND)) begin
      pc_d      = buf_addr;
      buf_clear = 1'b1;
      state_d   = S_RUN;
    end else if (advance) begin
      pc_d = pc_q + STEP_INC;
    end else if (branch_flag_i) begin
      buf_capture = 1'b1;
      state_d     = S_PEND;
    end
  end

  // State, PC and fetch-enable registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_OFF;
      pc_q    <= RESET_VEC;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= (state_d != S_OFF);
    end
  end

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture_i (buf_capture),
    .clear_i   (buf_clear),
    .addr_i    (branch_target_address_i),
    .valid_o   (buf_valid),
    .addr_o    (buf_addr)
  );

`ifdef PC_GEN_MISALIGN_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

  logic misalign_q, misalign_d;

  // Flag any flush or branch target not aligned to STEP as it is loaded or captured
  always_comb begin
    misalign_d = 1'b0;
    if (state_q != S_OFF) begin
      if (flush) begin
        misalign_d = |(new_pc & ALIGN_MASK);
      end else if (branch_flag_i) begin
        misalign_d = |(branch_target_address_i & ALIGN_MASK);
      end
    end
  end

  // One-cycle misalignment pulse register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`endif

  assign pc           = pc_q;
  assign ce           = ce_q;
  assign pend_valid_o = buf_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen (ADDR_W=16, RESET_VEC=0x100, STEP=4).
// Directed scenarios followed by randomized cycles; a reference model pushes
// expected values into a queue that an independent monitor pops and checks.
// Misalignment checks are included when PC_GEN_MISALIGN_EN is defined.
module tb_pc_gen;

   localparam int          AW   = 16;
   localparam logic [15:0] RV   = 16'h0100;
   localparam int          STEP = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [5:0]  pcStall;
   logic        branchFlag;
   logic [15:0] branchTarget;
   logic        flush;
   logic [15:0] newPc;
   logic        fetchGnt;
   logic [15:0] pc;
   logic        ce;
   logic        fetchReq;
   logic        pendValid;
`ifdef PC_GEN_MISALIGN_EN
   logic        misalign;
`endif

   typedef struct {
      logic        fetchReq;
      logic [15:0] pc;
      logic        ce;
      logic        pend;
      logic        mis;
   } expItem_t;

   expItem_t expQ[$];

   int nVectors     = 0;
   int nMiscompares = 0;

   // Reference model state: running flag, PC, and one-entry pending redirect
   bit          mOn;
   logic [15:0] mPc;
   bit          mPendValid;
   logic [15:0] mPendAddr;

   // Free-running clock
   always #5 clock = ~clock;

   pc_gen #(
      .ADDR_W    (AW),
      .RESET_VEC (RV),
      .STEP      (STEP),
      .STALL_W   (6)
   ) dut (
      .clk                     (clock),
      .reset_n                 (reset_n),
      .pc_stall                (pcStall),
      .branch_flag_i           (branchFlag),
      .branch_target_address_i (branchTarget),
      .flush                   (flush),
      .new_pc                  (newPc),
      .fetch_gnt_i             (fetchGnt),
      .pc                      (pc),
      .ce                      (ce),
      .fetch_req_o             (fetchReq),
`ifdef PC_GEN_MISALIGN_EN
      .misalign_o              (misalign),
`endif
      .pend_valid_o            (pendValid)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit isMisaligned(input logic [15:0] a);
      return (int'(a) % STEP) != 0;
   endfunction

   // Drive one cycle of inputs and predict the result of the following edge
   task automatic applyStimulus(input logic [5:0] stall, input logic br, input logic [15:0] bta,
                                input logic fl, input logic [15:0] npc, input logic gnt);
      expItem_t it;
      bit       adv;
      @(negedge clock);
      reset_n      = 1'b1;
      pcStall      = stall;
      branchFlag   = br;
      branchTarget = bta;
      flush        = fl;
      newPc        = npc;
      fetchGnt     = gnt;
      it.fetchReq  = mOn && !stall[0] && !fl;
      it.mis       = 1'b0;
      adv          = it.fetchReq && gnt;
      if (!mOn) begin
         mOn = 1'b1;
      end else if (fl) begin
         mPc        = npc;
         mPendValid = 1'b0;
         it.mis     = isMisaligned(npc);
      end else if (adv && br) begin
         mPc        = bta;
         mPendValid = 1'b0;
         it.mis     = isMisaligned(bta);
      end else if (adv && mPendValid) begin
         mPc        = mPendAddr;
         mPendValid = 1'b0;
      end else if (adv) begin
         mPc = 16'((int'(mPc) + STEP) % 65536);
      end else if (br) begin
         mPendValid = 1'b1;
         mPendAddr  = bta;
         it.mis     = isMisaligned(bta);
      end
      it.pc   = mPc;
      it.ce   = mOn;
      it.pend = mPendValid;
      expQ.push_back(it);
   endtask

   // Assert reset for one cycle mid-run; everything returns to reset values
   task automatic applyReset();
      expItem_t it;
      @(negedge clock);
      reset_n    = 1'b0;
      mOn        = 1'b0;
      mPc        = RV;
      mPendValid = 1'b0;
      mPendAddr  = 16'h0;
      it.fetchReq = 1'b0;
      it.pc       = RV;
      it.ce       = 1'b0;
      it.pend     = 1'b0;
      it.mis      = 1'b0;
      expQ.push_back(it);
   endtask

   // Monitor: combinational request checked just before the edge, registered outputs just after
   initial begin
      expItem_t mon;
      forever begin
         @(negedge clock);
         #4;
         if (expQ.size() > 0) begin
            mon = expQ.pop_front();
            checkOutput("fetch_req_o", 32'(fetchReq), 32'(mon.fetchReq));
            @(posedge clock);
            #1;
            checkOutput("pc", 32'(pc), 32'(mon.pc));
            checkOutput("ce", 32'(ce), 32'(mon.ce));
            checkOutput("pend_valid_o", 32'(pendValid), 32'(mon.pend));
`ifdef PC_GEN_MISALIGN_EN
            checkOutput("misalign_o", 32'(misalign), 32'(mon.mis));
`endif
         end
      end
   end

   // Stimulus: directed scenarios then randomized traffic
   initial begin
      logic [15:0] rTarget;
      logic [15:0] rNewPc;
      reset_n      = 1'b0;
      pcStall      = '0;
      branchFlag   = 1'b0;
      branchTarget = '0;
      flush        = 1'b0;
      newPc        = '0;
      fetchGnt     = 1'b0;
      mOn          = 1'b0;
      mPc          = RV;
      mPendValid   = 1'b0;
      mPendAddr    = 16'h0;
      #12;
      checkOutput("reset pc", 32'(pc), 32'(RV));
      checkOutput("reset ce", 32'(ce), 32'h0);
      checkOutput("reset fetch_req_o", 32'(fetchReq), 32'h0);
      checkOutput("reset pend_valid_o", 32'(pendValid), 32'h0);

      $display("[TB] sequential fetch after reset release");
      repeat (4) applyStimulus(6'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

      $display("[TB] branch during stall is held pending");
      applyStimulus(6'b1, 1'b1, 16'h2000, 1'b0, 16'h0, 1'b1);
      repeat (2) applyStimulus(6'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      repeat (2) applyStimulus(6'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

      $display("[TB] flush discards pending redirect");
      applyStimulus(6'b1, 1'b1, 16'h2000, 1'b0, 16'h0, 1'b1);
      applyStimulus(6'b1, 1'b0, 16'h0, 1'b1, 16'h0080, 1'b0);
      repeat (2) applyStimulus(6'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

      $display("[TB] newer ungranted branch overwrites older");
      applyStimulus(6'b0, 1'b1, 16'h0300, 1'b0, 16'h0, 1'b0);
      applyStimulus(6'b0, 1'b1, 16'h0400, 1'b0, 16'h0, 1'b0);
      repeat (2) applyStimulus(6'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

      $display("[TB] address wrap at top of range");
      applyStimulus(6'b0, 1'b0, 16'h0, 1'b1, 16'hFFFC, 1'b1);
      repeat (2) applyStimulus(6'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

      $display("[TB] misaligned branch target");
      applyStimulus(6'b0, 1'b1, 16'h1002, 1'b0, 16'h0, 1'b1);
      repeat (2) applyStimulus(6'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

      $display("[TB] reset while a redirect is pending");
      applyStimulus(6'b1, 1'b1, 16'h3000, 1'b0, 16'h0, 1'b1);
      applyReset();
      repeat (3) applyStimulus(6'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 500; i++) begin
         rTarget = 16'($urandom_range(0, 65535));
         rNewPc  = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 3) != 0) rTarget = rTarget & 16'hFFFC;
         if ($urandom_range(0, 3) != 0) rNewPc  = rNewPc & 16'hFFFC;
         if ($urandom_range(0, 149) == 0) begin
            applyReset();
         end else begin
            applyStimulus({5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0)},
                          ($urandom_range(0, 3) == 0), rTarget,
                          ($urandom_range(0, 9) == 0), rNewPc,
                          ($urandom_range(0, 9) < 7));
         end
      end

      for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clock);
      if (expQ.size() != 0) begin
         nVectors++;
         nMiscompares++;
         $display("[TB] FAIL drain: %0d items left, expected 0", expQ.size());
      end
      @(posedge clock);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the CPU fetch stage, the next generation of the fixed 32-bit PC register. It adds a configurable address width, reset vector and step, and a request/grant handshake to instruction memory. Branch redirects that arrive while fetch is stalled or ungranted are captured in a one-entry pending-redirect register instead of being lost. It sits between the ctrl/stall unit, the ID-stage branch resolver, the exception unit and the instruction-memory port.

## Interface
- ADDR_W, 32: PC / address width in bits, 8..64.
- RESET_VEC, 0: PC value loaded on reset, ADDR_W bits.
- STEP, 4: sequential increment in bytes; power of two, 1..8.
- STALL_W, 6: width of the pipeline stall vector.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_stall  in  STALL_W  stall vector; only bit 0 (PC stage) is used.
- branch_flag_i  in  1  branch/jump taken this cycle.
- branch_target_address_i  in  ADDR_W  branch target.
- flush  in  1  exception/eret flush; highest priority.
- new_pc  in  ADDR_W  handler/return address, valid with flush.
- fetch_gnt_i  in  1  instruction memory accepts the current request.
- pc  out  ADDR_W  current fetch address, registered.
- ce  out  1  fetch enable, registered; 0 in S_OFF.
- fetch_req_o  out  1  fetch request, combinational.
- pend_valid_o  out  1  a redirect is held pending, registered.
- misalign_o  out  1  misaligned-target pulse; present only with PC_GEN_MISALIGN_EN, registered.

## Operation
- States: S_OFF (after reset), S_RUN, S_PEND (pending redirect held). ce = (state != S_OFF).
- S_OFF -> S_RUN on the first clk edge after reset release; no PC update on that edge.
- fetch_req_o = ce & !pc_stall[0] & !flush.
- advance = fetch_req_o & fetch_gnt_i.
- Next-PC priority at each edge, with state != S_OFF:
  1. flush: pc <= new_pc. Any pending redirect is discarded; go to S_RUN.
  2. advance & branch_flag_i: pc <= branch_target_address_i; pending is cleared.
  3. advance & S_PEND: pc <= pending address; go to S_RUN.
  4. advance: pc <= pc + STEP, truncated to ADDR_W (wraps from all-ones to 0).
  5. !advance & branch_flag_i: pending <= branch_target_address_i; go to S_PEND. A newer branch overwrites an older pending one.
  6. Otherwise: hold.
- Branch and flush inputs are ignored in S_OFF.

## Timing
- Reset values: pc = RESET_VEC, ce = 0, state = S_OFF, pend_valid_o = 0, pending address = 0, misalign_o = 0. fetch_req_o is therefore 0.
- An asynchronous reset assertion mid-operation discards the pending redirect immediately.
- Redirect latency: pc shows the target one edge after the qualifying flush, or after the qualifying branch with advance.
- Pending redirect: applied on the first edge where advance is 1; at least 1 cycle after capture.
- With fetch_gnt_i tied 1 and no stall, pc advances by STEP every cycle starting from the 2nd edge after reset release.
- flush asserted together with stall or without grant still updates pc on the next edge.

## Configuration
- PC_GEN_MISALIGN_EN defined:
  - Any target loaded into pc or pending (new_pc, branch target) with bits [log2(STEP)-1:0] nonzero raises misalign_o for exactly one cycle, on the edge the target is loaded/captured.
  - The address is still used unmodified.
- PC_GEN_MISALIGN_EN undefined:
  - The misalign_o port is absent and no check logic is built.

## Structure
- Shared cpu package: state encoding typedef (S_OFF, S_RUN, S_PEND) and the default RESET_VEC / STEP constants.
- One sub-module, pc_redirect_buf: the pending-address register plus valid bit, with capture, clear and overwrite inputs.
- The top module holds the FSM, the PC register and the next-PC mux.

## Test plan
- Reset release, gnt = 1, no stall, RESET_VEC = 0x100 -> ce = 1 after edge 1; pc = 0x100, 0x104, 0x108 on the following edges.
- pc_stall[0] = 1, branch to 0x2000 for one cycle, stall released 3 cycles later -> pend_valid_o = 1 during the stall; pc = 0x2000 one edge after release; pend_valid_o = 0.
- Pending 0x2000 held, flush with new_pc = 0x80 -> pc = 0x80; pend_valid_o = 0; 0x2000 never appears.
- Branch to 0x300 with gnt = 0, then branch to 0x400 with gnt = 0, then gnt = 1 -> pc = 0x400.
- ADDR_W = 16, pc = 0xFFFC, STEP = 4 -> next pc = 0x0000.
- PC_GEN_MISALIGN_EN defined, branch target 0x1002 with advance -> pc = 0x1002; misalign_o high for exactly 1 cycle.
